int_vector_ctrl: RTL
====================

INT_VECTOR_CTRL -- requirements
Module: int_vector_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100: vector address for source 0.
REQ-002 Parameter VEC_STRIDE, default 32'h0000_0010: byte spacing between consecutive source vectors.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 done  input  4  peripheral completion requests; done[0]=done1 … done[3]=done4.
REQ-006 int_ack  input  1  one-cycle pulse from the processor: interrupt taken, PC redirected.
REQ-007 eoi  input  1  one-cycle end-of-interrupt pulse from the processor: handler finished.
REQ-008 mask_we  input  1  mask register write strobe.
REQ-009 mask_wd  input  4  mask write data; bit=1 masks that source.
REQ-010 interrupt  output  1  request to the processor interrupt encoder.
REQ-011 int_addr  output  32  vector address of the granted source, stable while interrupt or SERVICE.
REQ-012 active_id  output  2  index of the granted source.
REQ-013 pending  output  4  current pending bits.

Function
REQ-014 A rising edge on done[i] (sampled high, previous sample low) SHALL set pending[i] on the next clk edge; levels without edges SHALL NOT re-set pending.
REQ-015 FSM states: IDLE, REQ, SERVICE.
REQ-016 In IDLE, if (pending & ~mask) != 0, the FSM SHALL go to REQ and latch active_id = lowest set index, int_addr = VEC_BASE + active_id*VEC_STRIDE (32-bit, wrap-around modulo 2^32).
REQ-017 interrupt SHALL be 1 only in REQ; latency from done edge to interrupt SHALL be 2 cycles.
REQ-018 In REQ, int_ack SHALL clear pending[active_id] and move the FSM to SERVICE on the same edge.
REQ-019 In SERVICE, eoi SHALL return the FSM to IDLE; the next arbitration occurs in IDLE the following cycle.
REQ-020 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-021 A new edge on done[active_id] coinciding with its clear SHALL leave pending set (set wins).
REQ-022 Edges arriving in REQ or SERVICE SHALL be recorded in pending, never counted beyond 1, and SHALL NOT pre-empt the active source.
REQ-023 mask_we SHALL update the mask on the next edge; masking the active source in REQ/SERVICE SHALL NOT withdraw the request or grant.
REQ-024 Masked pending bits SHALL be retained and become eligible when unmasked.

Reset
REQ-025 While reset=0: state=IDLE, pending=0, mask=0, edge-detect history=0, interrupt=0, active_id=0, int_addr=VEC_BASE.
REQ-026 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the grant immediately; no pending bit survives.

Configuration
REQ-027 Macro INT_VEC_SYNC_EN defined: each done bit SHALL pass a two-flop synchronizer before edge detection, giving a 4-cycle done-to-interrupt latency.
REQ-028 INT_VEC_SYNC_EN undefined: no synchronizer; latency per REQ-017.

Structure
REQ-029 Package int_vec_pkg SHALL hold NUM_SRC=4, the state enum (IDLE/REQ/SERVICE), and default VEC_BASE/VEC_STRIDE constants.
REQ-030 Sub-module int_prio_enc SHALL implement the 4-bit fixed-priority (lowest index wins) encoder with valid output.

Verification
REQ-031 Reset release, done=4'b0100 rising edge -> pending=4'b0100 next cycle, interrupt=1 two cycles after edge, active_id=2, int_addr=32'h0000_0120.
REQ-032 done=4'b1010 edges same cycle -> grant id 1 (int_addr 32'h0000_0110); after int_ack and eoi -> grant id 3 (32'h0000_0130).
REQ-033 mask_wd=4'b0001 written, then done[0] edge -> pending=4'b0001, interrupt stays 0; write mask 0 -> interrupt after 1 cycle with id 0.
REQ-034 In REQ for id 0, int_ack and a new done[0] edge same cycle -> state SERVICE, pending[0]=1; after eoi -> re-grant id 0.
REQ-035 Reset=0 asserted during SERVICE with pending=4'b1100 -> interrupt=0, pending=0, state IDLE with no clock edge required.
REQ-036 With INT_VEC_SYNC_EN, done[3] edge -> interrupt exactly 4 cycles later, int_addr=32'h0000_0130.

Source files
------------

// File: rtl/int_vec_pkg.sv
// rtl/int_vec_pkg.sv - shared constants, FSM state type and vector address helper
package int_vec_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  // Wraps modulo 2^32 by construction of the 32-bit result.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [ID_W-1:0] id);
    return base + stride * {{(32-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - fixed-priority encoder, lowest set index wins
module int_prio_enc
  import int_vec_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_vector_ctrl.sv
// rtl/int_vector_ctrl.sv - vectored interrupt controller with edge capture and masking
// Define INT_VEC_SYNC_EN to put a two-flop synchronizer on each done input.
module int_vector_ctrl
  import int_vec_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] done,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wd,
  output logic               interrupt,
  output logic [31:0]        int_addr,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_SRC-1:0] pending
);

  state_t             state, state_next;
  logic [NUM_SRC-1:0] done_s, done_hist, rise, mask, clr;
  logic [ID_W-1:0]    enc_idx;
  logic               enc_valid;

`ifdef INT_VEC_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= done;
      sync2 <= sync1;
    end
  end

  assign done_s = sync2;
`else
  assign done_s = done;
`endif

  assign rise = done_s & ~done_hist;

  int_prio_enc u_prio_enc (
    .req   (pending & ~mask),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enc_valid) state_next = REQ;
      REQ:     if (int_ack)   state_next = SERVICE;
      SERVICE: if (eoi)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign interrupt = (state == REQ);

  // Clear is applied before the new edge is OR-ed in, so a coincident edge keeps the bit set.
  assign clr = (state == REQ && int_ack) ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << active_id) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_hist <= '0;
      pending   <= '0;
      mask      <= '0;
      active_id <= '0;
      int_addr  <= VEC_BASE;
    end else begin
      done_hist <= done_s;
      pending   <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wd;
      if (state == IDLE && enc_valid) begin
        active_id <= enc_idx;
        int_addr  <= vec_addr(VEC_BASE, VEC_STRIDE, enc_idx);
      end
    end
  end

endmodule
